player_motion: RTL



---
 rtl/game_pkg.sv | 29 ++
 rtl/player_motion_if.sv | 29 ++
 rtl/step_timer.sv | 29 ++
 rtl/player_motion.sv | 104 ++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: one-hot direction codes, grid defaults and
// the direction helper functions used by motion and rendering logic.
package game_pkg;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } motion_state_t;

  function automatic logic is_onehot4(input logic [3:0] d);
    return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic is_opposite(input logic [3:0] a, input logic [3:0] b);
    return ((a == DIR_RIGHT) && (b == DIR_LEFT))  ||
           ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP));
  endfunction

endpackage

// File: rtl/player_motion_if.sv
// Bundle between the input/render side and player_motion. move_dir and
// enable are level-held requests (no handshake); step_valid and wrapped
// are single-cycle pulses that qualify the registered position/heading.
interface player_motion_if #(
  parameter int X_W = 6,
  parameter int Y_W = 5
);
  import game_pkg::*;

  logic [3:0]     move_dir;
  logic           enable;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic [3:0]     head_dir;
  logic           step_valid;
  logic           wrapped;
  motion_state_t  state;

  modport master (
    output move_dir, enable,
    input  pos_x, pos_y, head_dir, step_valid, wrapped, state
  );

  modport slave (
    input  move_dir, enable,
    output pos_x, pos_y, head_dir, step_valid, wrapped, state
  );

endinterface

// File: rtl/step_timer.sv
// Free-running step divider: tick is high on the terminal count while
// run is asserted; the count is forced to zero whenever run drops.
module step_timer #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = run && (count == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run || (count == TERM)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Player head motion: IDLE/RUN control, reversal-safe direction filter
// and wrapping one-cell-per-tick position update.
module player_motion
  import game_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  logic           clk,
  input  logic           rst,
  player_motion_if.slave bus
);

  localparam logic [X_W-1:0] LAST_X = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] LAST_Y = Y_W'(GRID_H - 1);

  motion_state_t  state, next_state;
  logic           run, tick, accept, next_wrap;
  logic [X_W-1:0] pos_x, next_x;
  logic [Y_W-1:0] pos_y, next_y;
  logic [3:0]     head_dir, pending_dir;
  logic           step_valid, wrapped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.enable)  next_state = ST_RUN;
      ST_RUN:  if (!bus.enable) next_state = ST_IDLE;
    endcase
  end

  // Dropping enable at the terminal count suppresses the step and clears the count.
  assign run = (state == ST_RUN) && bus.enable;

  step_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  // Reversal is judged against the committed heading, not the pending one.
  assign accept = is_onehot4(bus.move_dir) && !is_opposite(bus.move_dir, head_dir);

  always_comb begin
    next_x    = pos_x;
    next_y    = pos_y;
    next_wrap = 1'b0;
    case (pending_dir)
      DIR_RIGHT: if (pos_x == LAST_X) begin next_x = '0;     next_wrap = 1'b1; end
                 else                       next_x = pos_x + 1'b1;
      DIR_LEFT:  if (pos_x == '0)     begin next_x = LAST_X; next_wrap = 1'b1; end
                 else                       next_x = pos_x - 1'b1;
      DIR_UP:    if (pos_y == '0)     begin next_y = LAST_Y; next_wrap = 1'b1; end
                 else                       next_y = pos_y - 1'b1;
      DIR_DOWN:  if (pos_y == LAST_Y) begin next_y = '0;     next_wrap = 1'b1; end
                 else                       next_y = pos_y + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x       <= X_W'(START_X);
      pos_y       <= Y_W'(START_Y);
      head_dir    <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      step_valid  <= 1'b0;
      wrapped     <= 1'b0;
    end else begin
      step_valid <= tick;
      wrapped    <= tick && next_wrap;
      if (tick) begin
        pos_x    <= next_x;
        pos_y    <= next_y;
        head_dir <= pending_dir;
      end else if (accept) begin
        pending_dir <= bus.move_dir;
      end
    end
  end

  assign bus.pos_x      = pos_x;
  assign bus.pos_y      = pos_y;
  assign bus.head_dir   = head_dir;
  assign bus.step_valid = step_valid;
  assign bus.wrapped    = wrapped;
  assign bus.state      = state;

endmodule
